bcd_upcounter_scan: RTL and testbench
=====================================

Name: bcd_upcounter_scan

Overview:
- Synchronous 4-digit decimal up-counter, counting 0000 to 9999.
- Advances by one on each rising edge of a debounced push-button level.
- Drives all four seven-segment digits through time-multiplexed anode scanning.
- Sits between the existing debounce block and the board's 7-seg pins; complements the down-counting single-digit display path.

Parameters:
- SCAN_BITS, 17: width of the free-running refresh counter. The digit select is its top 2 bits, so each digit is lit for 2^(SCAN_BITS-2) cycles. Sim uses 4.

Ports:
- clk  input  1  system clock; all state in this domain.
- reset  input  1  reset reset, asynchronous, active-high.
- btn  input  1  debounced button level, already synchronous to clk.
- leds  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- ano  output  4  digit anodes, active-low one-hot; ano[0] is the ones digit.
- ovf  output  1  one-cycle pulse on wrap from 9999 to 0000.
- count  output  16  packed BCD {d3,d2,d1,d0}, for debug and for the bench.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - count = 16'h0000, ovf = 0.
  - Refresh counter = 0.
  - ano = 4'b1111 (all off), leds = 7'b1111111.
  - btn_q = 1, so a button held through reset release produces no count.
- Edge detect:
  - btn_q registers btn every cycle.
  - step = btn & ~btn_q (combinational).
  - Exactly one step per press, however long the press is held.
- Counting:
  - On a clock edge with step = 1, count increments by one in BCD. It is visible after that same edge, so latency is 0 cycles from the sampled edge.
  - Each digit: if carry_in and d == 9, then d becomes 0 and carry_out = 1; else if carry_in, d = d + 1.
  - carry_in to d0 is step; the carry ripples combinationally through d1 to d3 within the same cycle.
  - At 9999 with step: count becomes 0000 and ovf = 1 for exactly that one cycle; otherwise ovf = 0.
  - Invalid BCD codes are unreachable. The decoder maps them to blank.
- Scan:
  - The refresh counter increments every cycle and wraps freely.
  - sel = refresh[SCAN_BITS-1:SCAN_BITS-2].
  - leds and ano are registered from sel and the current count (1-cycle latency):
    - sel 0: ano = 1110, shows d0
    - sel 1: ano = 1101, shows d1
    - sel 2: ano = 1011, shows d2
    - sel 3: ano = 0111, shows d3
  - Exactly one anode is low at any time after the first post-reset edge.
- Segment codes (active-low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- Simultaneous step and sel change: the two are independent. The register captures the new sel together with the pre-step count; the updated value appears on the following edge.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit i (i > 0) is driven blank when it and every higher digit are 0.
  - d0 is always shown, so 0000 displays "0" and 0105 displays "105".
  - Anode scanning is unchanged; a blanked digit still has its anode low with leds = 1111111.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package bcd_pkg holds:
  - DIGITS = 4.
  - SEG_0 to SEG_9 and SEG_BLANK constants.
  - ANO_OFF = 4'b1111.
  - Function seg_decode(4-bit BCD) returning 7 bits, with default SEG_BLANK.
- Sub-module bcd_digit: one decade cell.
  - Ports: clk, reset, cin, d[3:0], cout.
  - Instantiated 4 times as a ripple chain.
- The top level holds the edge detect, ovf, refresh counter, and output registers.

Test Plan (SCAN_BITS = 4):
- Reset: assert reset mid-count at 0042 → count = 0000, ano = 1111, leds = 1111111 with no clock edge; after release, first edge gives ano = 1110.
- Press and hold: drive btn high for 50 cycles → count = 0001 only.
- Press count: 10 separate presses → count = 0010 (d0 wraps 9→0, d1 = 1).
- Cascade: 1000 presses reach 1000; preload by presses to 0999, then one press → 1000 with ovf = 0.
- Overflow: at 9999, one press → count = 0000 and ovf high exactly 1 cycle.
- Scan: hold count 1234 → ano cycles 1110, 1101, 1011, 0111 every 4 cycles with leds = 0011001, 0110000, 0100100, 1111001.
- With LZ_BLANK_EN at 0007: the d1 to d3 slots show 1111111; d0 shows 1111000.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_pkg                                                      |
// | Description : Shared constants and segment decoder for the BCD counter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bcd_pkg;

    localparam int DIGITS = 4;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANO_OFF   = 4'b1111;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_digit                                                    |
// | Description : One decade cell; carry-out is combinational for rippling.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       cin,
    output logic [3:0] d,
    output logic       cout
);

    assign cout = cin && (d == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d <= 4'd0;
        end else if (cin) begin
            d <= cout ? 4'd0 : d + 4'd1;
        end
    end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_upcounter_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_upcounter_scan                                           |
// | Description : 4-digit BCD button counter with multiplexed 7-seg scanning.  |
// |               Define LZ_BLANK_EN to blank leading zero digits.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_upcounter_scan
    import bcd_pkg::*;
#(
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    output logic [6:0]  leds,
    output logic [3:0]  ano,
    output logic        ovf,
    output logic [15:0] count
);

    logic                 r_btn_q;
    logic                 w_step;
    logic [DIGITS:0]      w_carry;
    logic [3:0]           w_digit [DIGITS];
    logic [SCAN_BITS-1:0] r_refresh;
    logic [1:0]           w_sel;
    logic [DIGITS-1:0]    w_blank;
    logic [6:0]           w_leds_nxt;
    logic [3:0]           w_ano_nxt;

    // btn_q resets high so a button held through reset release does not count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_q <= 1'b1;
        end else begin
            r_btn_q <= btn;
        end
    end

    assign w_step     = btn & ~r_btn_q;
    assign w_carry[0] = w_step;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk   (clk),
                .reset (reset),
                .cin   (w_carry[i]),
                .d     (w_digit[i]),
                .cout  (w_carry[i+1])
            );
            assign count[4*i +: 4] = w_digit[i];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= w_carry[DIGITS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    assign w_sel = r_refresh[SCAN_BITS-1 -: 2];

`ifdef LZ_BLANK_EN
    // A digit is blank when it and every higher digit are zero; d0 always shows
    always_comb begin
        logic w_zrun;
        w_blank = '0;
        w_zrun  = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zrun     = w_zrun & (w_digit[i] == 4'd0);
            w_blank[i] = w_zrun;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_ano_nxt  = ~(4'b0001 << w_sel);
        w_leds_nxt = w_blank[w_sel] ? SEG_BLANK : seg_decode(w_digit[w_sel]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ano  <= ANO_OFF;
            leds <= SEG_BLANK;
        end else begin
            ano  <= w_ano_nxt;
            leds <= w_leds_nxt;
        end
    end

endmodule : bcd_upcounter_scan
`default_nettype wire

// File: tb/tb_bcd_upcounter_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bcd_upcounter_scan                                        |
// | Description : Directed self-checking bench for bcd_upcounter_scan.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bcd_upcounter_scan;

    localparam int SCAN_BITS = 4;

    logic        clk;
    logic        reset;
    logic        btn;
    logic [6:0]  leds;
    logic [3:0]  ano;
    logic        ovf;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    logic [6:0] seg_tab [10];
    logic [3:0] ano_tab [4];

    bcd_upcounter_scan #(.SCAN_BITS(SCAN_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .leds  (leds),
        .ano   (ano),
        .ovf   (ovf),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release: the scan position the bench expects
    always @(posedge clk or posedge reset) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    // Scan 16 cycles; digits dv[sel] with blank mask bm[sel]
    task automatic scan_check(input string tag, input int dv [4], input logic [3:0] bm);
        int sel;
        logic [6:0] exp_leds;
        for (int k = 0; k < 16; k++) begin
            sel      = ((ncyc - 1) % 16) / 4;
            exp_leds = bm[sel] ? 7'b1111111 : seg_tab[dv[sel]];
            chk({tag, "_ano"},  {12'd0, ano},  {12'd0, ano_tab[sel]});
            chk({tag, "_leds"}, {9'd0, leds},  {9'd0, exp_leds});
            tick();
        end
    endtask

    initial begin
        int d1234 [4];
        int d0007 [4];
        logic [3:0] lz_mask;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        ano_tab[0] = 4'b1110; ano_tab[1] = 4'b1101; ano_tab[2] = 4'b1011; ano_tab[3] = 4'b0111;
        d1234 = '{4, 3, 2, 1};
        d0007 = '{7, 0, 0, 0};
`ifdef LZ_BLANK_EN
        lz_mask = 4'b1110;
`else
        lz_mask = 4'b0000;
`endif

        // Button held through reset release must not count
        btn   = 1'b1;
        reset = 1'b1;
        #12;
        chk("rst_count", count, 16'h0000);
        chk("rst_ano",   {12'd0, ano},  16'h000F);
        chk("rst_leds",  {9'd0, leds},  16'h007F);
        chk("rst_ovf",   {15'd0, ovf},  16'h0000);
        reset = 1'b0;
        tick();
        chk("first_ano", {12'd0, ano}, 16'h000E);
        tick(); tick();
        chk("held_thru_rst", count, 16'h0000);
        btn = 1'b0;
        tick();

        // Reach 0042 then reset asynchronously mid-cycle
        for (int i = 0; i < 42; i++) press();
        chk("count_42", count, 16'h0042);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", count, 16'h0000);
        chk("async_ano",   {12'd0, ano},  16'h000F);
        chk("async_leds",  {9'd0, leds},  16'h007F);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_ano",  {12'd0, ano},  16'h000E);
        chk("post_rst_leds", {9'd0, leds},  {9'd0, seg_tab[0]});

        // Press and hold for 50 cycles counts once
        btn = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        btn = 1'b0;
        tick();
        chk("hold_50", count, 16'h0001);

        // Ten separate presses from zero
        do_reset();
        for (int i = 0; i < 10; i++) press();
        chk("press_10", count, 16'h0010);

        // Cascade 0999 -> 1000
        for (int i = 0; i < 989; i++) press();
        chk("count_0999", count, 16'h0999);
        btn = 1'b1;
        tick();
        chk("cascade_1000", count, 16'h1000);
        chk("cascade_ovf",  {15'd0, ovf}, 16'h0000);
        btn = 1'b0;
        tick();

        // Scan with count held at 1234
        for (int i = 0; i < 234; i++) press();
        chk("count_1234", count, 16'h1234);
        scan_check("scan1234", d1234, 4'b0000);

        // Overflow 9999 -> 0000
        for (int i = 0; i < 8765; i++) press();
        chk("count_9999", count, 16'h9999);
        chk("pre_ovf", {15'd0, ovf}, 16'h0000);
        btn = 1'b1;
        tick();
        chk("wrap_count", count, 16'h0000);
        chk("wrap_ovf",   {15'd0, ovf}, 16'h0001);
        btn = 1'b0;
        tick();
        chk("ovf_one_cycle", {15'd0, ovf}, 16'h0000);
        chk("after_wrap", count, 16'h0000);

        // Leading-zero handling at 0007
        do_reset();
        for (int i = 0; i < 7; i++) press();
        chk("count_0007", count, 16'h0007);
        scan_check("scan0007", d0007, lz_mask);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_upcounter_scan
`default_nettype wire
